// File: rtl/ct_iu_fwd_wb_bcast.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// ct_iu_fwd_wb_bcast : IU pipe forward/writeback broadcast, ALU results merged with
//                      long-latency results through a small holding FIFO.
// Revision: 1.0
// ------------------------------------------------------------------------------------------
module ct_iu_fwd_wb_bcast #(
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_W     = 7,
  parameter int DATA_W     = 64
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              rtu_yy_xx_flush,
  input  logic              ex1_alu_dst_vld,
  input  logic [PREG_W-1:0] ex1_alu_dst_preg,
  input  logic [DATA_W-1:0] ex1_alu_data,
  input  logic              lng_res_vld,
  input  logic [PREG_W-1:0] lng_res_preg,
  input  logic [DATA_W-1:0] lng_res_data,
  output logic              lng_res_rdy,
  output logic              x_ex1_fwd_preg_vld,
  output logic [PREG_W-1:0] x_ex1_fwd_preg,
  output logic [DATA_W-1:0] x_ex1_fwd_preg_data,
  output logic              x_ex2_wb_preg_vld,
  output logic [PREG_W-1:0] x_ex2_wb_preg,
  output logic [DATA_W-1:0] x_ex2_wb_preg_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [PREG_W-1:0] preg_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wb_vld_q;
  logic [PREG_W-1:0] wb_preg_q;
  logic [DATA_W-1:0] wb_data_q;

  logic alu_sel, head_sel, ft_sel, fifo_empty, push, pop;

  assign fifo_empty  = (count_q == '0);
  assign alu_sel     = ex1_alu_dst_vld & ~rtu_yy_xx_flush;
  assign head_sel    = ~alu_sel & ~fifo_empty & ~rtu_yy_xx_flush;
  assign ft_sel      = ~alu_sel & fifo_empty & lng_res_vld & ~rtu_yy_xx_flush;
  // Readiness depends only on occupancy, so results are accepted under ALU ownership.
  assign lng_res_rdy = (count_q < CNT_W'(FIFO_DEPTH)) & ~rtu_yy_xx_flush;
  assign push        = lng_res_vld & lng_res_rdy & ~ft_sel;
  assign pop         = head_sel;

  always_comb begin
    x_ex1_fwd_preg_vld  = 1'b0;
    x_ex1_fwd_preg      = '0;
    x_ex1_fwd_preg_data = '0;
    if (alu_sel) begin
      x_ex1_fwd_preg_vld  = 1'b1;
      x_ex1_fwd_preg      = ex1_alu_dst_preg;
      x_ex1_fwd_preg_data = ex1_alu_data;
    end else if (head_sel) begin
      x_ex1_fwd_preg_vld  = 1'b1;
      x_ex1_fwd_preg      = preg_mem_q[rd_ptr_q];
      x_ex1_fwd_preg_data = data_mem_q[rd_ptr_q];
    end else if (ft_sel) begin
      x_ex1_fwd_preg_vld  = 1'b1;
      x_ex1_fwd_preg      = lng_res_preg;
      x_ex1_fwd_preg_data = lng_res_data;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      preg_mem_q[wr_ptr_q] <= lng_res_preg;
      data_mem_q[wr_ptr_q] <= lng_res_data;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst || rtu_yy_xx_flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // The writeback preg/data hold their last broadcast value while wb_vld is low.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      wb_vld_q  <= 1'b0;
      wb_preg_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_vld_q <= x_ex1_fwd_preg_vld;
      if (x_ex1_fwd_preg_vld) begin
        wb_preg_q <= x_ex1_fwd_preg;
        wb_data_q <= x_ex1_fwd_preg_data;
      end
    end
  end

  assign x_ex2_wb_preg_vld  = wb_vld_q;
  assign x_ex2_wb_preg      = wb_preg_q;
  assign x_ex2_wb_preg_data = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ct_iu_fwd_wb_bcast.sv
`default_nettype none
// Bench for ct_iu_fwd_wb_bcast: directed scenarios then constrained-random traffic,
// checked through EX1/EX2 scoreboards fed by a queue-based reference model.
module tb_ct_iu_fwd_wb_bcast;

  localparam int DEPTH = 2;

  typedef struct {
    logic        v;
    logic        r;
    logic [6:0]  p;
    logic [63:0] d;
  } ex_t;

  typedef struct {
    logic [6:0]  p;
    logic [63:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        alu_v = 1'b0;
  logic [6:0]  alu_p = '0;
  logic [63:0] alu_d = '0;
  logic        lng_v = 1'b0;
  logic [6:0]  lng_p = '0;
  logic [63:0] lng_d = '0;
  logic        rdy, fwd_v, wb_v;
  logic [6:0]  fwd_p, wb_p;
  logic [63:0] fwd_d, wb_d;

  int nchk = 0;
  int nerr = 0;

  ex_t  ex1_q[$];
  ex_t  wb_q[$];
  ent_t fifo_m[$];
  ex_t  wb_m;

  always #5 clk = ~clk;

  ct_iu_fwd_wb_bcast #(.FIFO_DEPTH(DEPTH), .PREG_W(7), .DATA_W(64)) dut (
    .forever_cpuclk      (clk),
    .cpurst              (rst),
    .rtu_yy_xx_flush     (flush),
    .ex1_alu_dst_vld     (alu_v),
    .ex1_alu_dst_preg    (alu_p),
    .ex1_alu_data        (alu_d),
    .lng_res_vld         (lng_v),
    .lng_res_preg        (lng_p),
    .lng_res_data        (lng_d),
    .lng_res_rdy         (rdy),
    .x_ex1_fwd_preg_vld  (fwd_v),
    .x_ex1_fwd_preg      (fwd_p),
    .x_ex1_fwd_preg_data (fwd_d),
    .x_ex2_wb_preg_vld   (wb_v),
    .x_ex2_wb_preg       (wb_p),
    .x_ex2_wb_preg_data  (wb_d)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, then advance the reference model.
  task automatic cyc(input logic r, input logic f, input logic av, input logic [6:0] ap,
                     input logic [63:0] ad, input logic lv, input logic [6:0] lp,
                     input logic [63:0] ld, output logic acc);
    ex_t  e;
    ent_t h;
    logic ft;
    @(negedge clk);
    rst = r; flush = f; alu_v = av; alu_p = ap; alu_d = ad;
    lng_v = lv; lng_p = lp; lng_d = ld;
    e.v = 1'b0; e.r = 1'b0; e.p = '0; e.d = '0;
    acc = 1'b0; ft = 1'b0;
    if (r) begin
      fifo_m.delete();
      wb_m.v = 1'b0; wb_m.r = 1'b0; wb_m.p = '0; wb_m.d = '0;
    end else begin
      e.r = (fifo_m.size() < DEPTH) && !f;
      if (!f) begin
        if (av) begin
          e.v = 1'b1; e.p = ap; e.d = ad;
        end else if (fifo_m.size() > 0) begin
          h = fifo_m.pop_front();
          e.v = 1'b1; e.p = h.p; e.d = h.d;
        end else if (lv) begin
          e.v = 1'b1; e.p = lp; e.d = ld; ft = 1'b1; acc = 1'b1;
        end
      end
      if (e.r && lv && !ft) begin
        h.p = lp; h.d = ld;
        fifo_m.push_back(h);
        acc = 1'b1;
      end
      if (f) fifo_m.delete();
      ex1_q.push_back(e);
      wb_m.v = e.v;
      if (e.v) begin
        wb_m.p = e.p; wb_m.d = e.d;
      end
    end
    wb_q.push_back(wb_m);
  endtask

  // EX1 monitor: combinational bus and ready, sampled after the inputs settle.
  initial forever begin
    ex_t e;
    @(negedge clk);
    #2;
    if (ex1_q.size() > 0) begin
      e = ex1_q.pop_front();
      chk("lng_res_rdy", {63'd0, rdy}, {63'd0, e.r});
      chk("fwd_vld", {63'd0, fwd_v}, {63'd0, e.v});
      chk("fwd_preg", {57'd0, fwd_p}, {57'd0, e.p});
      chk("fwd_data", fwd_d, e.d);
    end
  end

  // EX2 monitor: registered bus, sampled just after the rising edge.
  initial forever begin
    ex_t w;
    @(posedge clk);
    #1;
    if (wb_q.size() > 0) begin
      w = wb_q.pop_front();
      chk("wb_vld", {63'd0, wb_v}, {63'd0, w.v});
      chk("wb_preg", {57'd0, wb_p}, {57'd0, w.p});
      chk("wb_data", wb_d, w.d);
    end
  end

  initial begin
    logic        acc;
    logic        hv;
    logic [6:0]  hp;
    logic [63:0] hd;
    logic        r, f, av;

    // Reset held two cycles with traffic present.
    cyc(1, 0, 1, 7'h11, 64'h1111, 1, 7'h12, 64'h1212, acc);
    cyc(1, 0, 1, 7'h11, 64'h1111, 1, 7'h12, 64'h1212, acc);
    // ALU only, then fall-through.
    cyc(0, 0, 1, 7'h15, 64'hDEAD, 0, 7'h0, 64'h0, acc);
    cyc(0, 0, 0, 7'h0, 64'h0, 1, 7'h22, 64'h1, acc);
    cyc(0, 0, 0, 7'h0, 64'h0, 0, 7'h0, 64'h0, acc);
    // Contention: ALU owns the slot while results queue up, then drain in order.
    cyc(0, 0, 1, 7'h01, 64'hA1, 1, 7'h30, 64'h300, acc);
    cyc(0, 0, 1, 7'h02, 64'hA2, 1, 7'h31, 64'h310, acc);
    cyc(0, 0, 1, 7'h03, 64'hA3, 1, 7'h32, 64'h320, acc);
    cyc(0, 0, 1, 7'h04, 64'hA4, 1, 7'h32, 64'h320, acc);
    for (int k = 0; k < 8 && !acc; k++)
      cyc(0, 0, 0, 7'h0, 64'h0, 1, 7'h32, 64'h320, acc);
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0, 7'h0, 64'h0, 0, 7'h0, 64'h0, acc);
    // Flush with a full FIFO and a valid ALU result.
    cyc(0, 0, 1, 7'h05, 64'hB1, 1, 7'h40, 64'h400, acc);
    cyc(0, 0, 1, 7'h06, 64'hB2, 1, 7'h41, 64'h410, acc);
    cyc(0, 1, 1, 7'h07, 64'hB3, 1, 7'h42, 64'h420, acc);
    cyc(0, 0, 0, 7'h0, 64'h0, 0, 7'h0, 64'h0, acc);
    cyc(0, 0, 0, 7'h0, 64'h0, 0, 7'h0, 64'h0, acc);

    // Random traffic; an unaccepted request is held stable until accepted or flushed.
    hv = 1'b0; hp = '0; hd = '0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 15) == 0);
      av = ($urandom_range(0, 9) < 6);
      if (!hv) begin
        hv = ($urandom_range(0, 1) == 1);
        hp = 7'($urandom);
        hd = {$urandom, $urandom};
      end
      cyc(r, f, av, 7'($urandom), {$urandom, $urandom}, hv, hp, hd, acc);
      if (acc || r || f) hv = 1'b0;
    end
    cyc(0, 0, 0, 7'h0, 64'h0, 0, 7'h0, 64'h0, acc);
    repeat (2) @(negedge clk);
    #3;
    chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    chk("ex1_queue_drained", 64'(ex1_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
`default_nettype wire
